// File: rtl/reg_write_arbiter.sv
// Purpose : round-robin arbiter sharing one bank of DEPTH x WIDTH write-enabled
//           registers among NREQ requesters under a level Req / pulse Ack handshake.
// Latency : Req sampled at edge N; WriteEn/WrData/AckVec valid in the cycle after
//           edge N+2; bank captures at edge N+3; one write per 3 cycles sustained.
// Backpressure: a requester simply holds Req/Addr/Data until its Ack pulse; losers
//           wait in IDLE arbitration, nothing is dropped except on reset.
//
// Ports:
//   i_Clk      rising-edge clock
//   i_Reset    synchronous active-low reset
//   i_ReqVec   per-requester write request (level, held until Ack)
//   i_AddrBus  requester i address at [i*AW +: AW]
//   i_DataBus  requester i data at [i*WIDTH +: WIDTH]
//   i_LockVec  per-requester lock request (used only when ARB_LOCK_EN is defined)
//   o_AckVec   one-hot 1-cycle pulse: write of requester i done
//   o_WriteEn  one-hot write enable to the register bank
//   o_WrData   write data to the register bank (holds outside a write)
//   o_Busy     high while in GRANT or WRITE
//   o_AddrErr  1-cycle pulse when the granted address is >= DEPTH
//
// Optional feature macro: ARB_LOCK_EN (a locking requester keeps the round-robin
// pointer on itself so it wins the next arbitration while it still requests).

module reg_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 8,
  parameter int WIDTH = 1,
  parameter int AW    = 3
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic [NREQ-1:0]       i_ReqVec,
  input  logic [NREQ*AW-1:0]    i_AddrBus,
  input  logic [NREQ*WIDTH-1:0] i_DataBus,
  input  logic [NREQ-1:0]       i_LockVec,
  output logic [NREQ-1:0]       o_AckVec,
  output logic [DEPTH-1:0]      o_WriteEn,
  output logic [WIDTH-1:0]      o_WrData,
  output logic                  o_Busy,
  output logic                  o_AddrErr
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t             r_state;
  logic [GW-1:0]      r_rr_ptr;
  logic [GW-1:0]      r_gnt;
  logic [AW-1:0]      r_addr;
  logic [WIDTH-1:0]   r_data;
  logic [DEPTH-1:0]   r_dec;
  logic               r_err_pend;
  logic [NREQ-1:0]    r_ack;
  logic [DEPTH-1:0]   r_wen;
  logic [WIDTH-1:0]   r_wrdata;
  logic               r_busy;
  logic               r_addr_err;

  logic               w_found;
  logic [GW-1:0]      w_win;
  logic [AW-1:0]      w_addr;
  logic [WIDTH-1:0]   w_data;
  logic [DEPTH-1:0]   w_dec;
  logic               w_addr_ok;
  logic [GW-1:0]      w_gnt_next;
  logic [NREQ-1:0]    w_gnt_oh;

  // Winner search starts at the round-robin pointer and wraps modulo NREQ;
  // the winner's address and data are selected in the same pass.
  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_win   = '0;
    w_addr  = '0;
    w_data  = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(r_rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!w_found && i_ReqVec[j]) begin
        w_found = 1'b1;
        w_win   = GW'(j);
        w_addr  = i_AddrBus[j*AW +: AW];
        w_data  = i_DataBus[j*WIDTH +: WIDTH];
      end
    end
  end

  // Out-of-range addresses decode to all-zero, so WriteEn stays quiet on error.
  always_comb begin
    w_dec     = '0;
    w_addr_ok = (int'(r_addr) < DEPTH);
    for (int d = 0; d < DEPTH; d++) begin
      if (int'(r_addr) == d) w_dec[d] = 1'b1;
    end
  end

  assign w_gnt_next = (r_gnt == GW'(NREQ-1)) ? '0 : r_gnt + GW'(1);
  assign w_gnt_oh   = NREQ'(1) << r_gnt;

`ifndef ARB_LOCK_EN
  // Lock input is part of the fixed port list but has no function here.
  logic w_unused_lock;
  assign w_unused_lock = &{1'b0, i_LockVec};
`endif

  always_ff @(posedge i_Clk) begin
    if (!i_Reset) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_gnt      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_dec      <= '0;
      r_err_pend <= 1'b0;
      r_ack      <= '0;
      r_wen      <= '0;
      r_wrdata   <= '0;
      r_busy     <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      r_ack      <= '0;
      r_wen      <= '0;
      r_addr_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt   <= w_win;
            r_addr  <= w_addr;
            r_data  <= w_data;
            r_state <= S_GRANT;
            r_busy  <= 1'b1;
          end
        end
        S_GRANT: begin
          r_dec      <= w_dec;
          r_err_pend <= !w_addr_ok;
          r_wrdata   <= r_data;
          r_state    <= S_WRITE;
          r_busy     <= 1'b1;
        end
        S_WRITE: begin
          r_wen      <= r_dec;
          r_addr_err <= r_err_pend;
          r_ack      <= w_gnt_oh;
`ifdef ARB_LOCK_EN
          // Holding the pointer on the locker makes it win the next search
          // while it still requests; releasing simply resumes rotation.
          if (i_LockVec[r_gnt]) r_rr_ptr <= r_gnt;
          else                  r_rr_ptr <= w_gnt_next;
`else
          r_rr_ptr   <= w_gnt_next;
`endif
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_AckVec  = r_ack;
  assign o_WriteEn = r_wen;
  assign o_WrData  = r_wrdata;
  assign o_Busy    = r_busy;
  assign o_AddrErr = r_addr_err;

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, lock;
  logic [11:0] addr;
  logic [3:0]  data;
  logic [3:0]  ack;
  logic [7:0]  wen;
  logic [0:0]  wrdata;
  logic        busy, err;

  // Second instance with DEPTH=6 for the address-error boundary.
  logic [3:0]  e_req;
  logic [11:0] e_addr;
  logic [3:0]  e_data;
  logic [3:0]  e_ack;
  logic [5:0]  e_wen;
  logic [0:0]  e_wrdata;
  logic        e_busy, e_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_write_arbiter #(.NREQ(4), .DEPTH(8), .WIDTH(1), .AW(3)) u_dut (
    .i_Clk(clk), .i_Reset(rst_n), .i_ReqVec(req), .i_AddrBus(addr),
    .i_DataBus(data), .i_LockVec(lock), .o_AckVec(ack), .o_WriteEn(wen),
    .o_WrData(wrdata), .o_Busy(busy), .o_AddrErr(err)
  );

  reg_write_arbiter #(.NREQ(4), .DEPTH(6), .WIDTH(1), .AW(3)) u_dut6 (
    .i_Clk(clk), .i_Reset(rst_n), .i_ReqVec(e_req), .i_AddrBus(e_addr),
    .i_DataBus(e_data), .i_LockVec(4'b0000), .o_AckVec(e_ack), .o_WriteEn(e_wen),
    .o_WrData(e_wrdata), .o_Busy(e_busy), .o_AddrErr(e_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = 4'b0; lock = 4'b0; e_req = 4'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req = 4'b1111; lock = 4'b0; e_req = 4'b0;
    addr = {3'd6, 3'd1, 3'd4, 3'd2}; data = 4'b1010;
    e_addr = '0; e_data = '0;
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({ack, wen, wrdata, busy, err} !== 15'd0) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d got ack=%b wen=%b wd=%b busy=%b err=%b exp all 0",
                 c, ack, wen, wrdata, busy, err);
      end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1 || wen !== 8'd0) begin
      failures++; $display("FAIL reset_release_busy got busy=%b wen=%b exp 1/0", busy, wen);
    end
    tick();
    checks++;
    if (ack !== 4'b0 || wen !== 8'd0) begin
      failures++; $display("FAIL reset_release_early got ack=%b wen=%b exp 0/0", ack, wen);
    end
    tick();
    checks++;
    if (ack !== 4'b0001 || wen !== 8'b0000_0100 || wrdata !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_ack got ack=%b wen=%b wd=%b exp 0001/00000100/0", ack, wen, wrdata);
    end
    req = 4'b0;
    tick();
  endtask

  task automatic test_single_write();
    do_reset();
    addr = '0; addr[8:6] = 3'd5; data = 4'b0100;
    req = 4'b0100;
    tick();
    checks++;
    if (busy !== 1'b1 || ack !== 4'b0) begin
      failures++; $display("FAIL single_c1 got busy=%b ack=%b exp 1/0000", busy, ack);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || wen !== 8'd0) begin
      failures++; $display("FAIL single_c2 got busy=%b wen=%b exp 1/0", busy, wen);
    end
    tick();
    checks++;
    if (ack !== 4'b0100 || wen !== 8'b0010_0000 || wrdata !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_c3 got ack=%b wen=%b wd=%b busy=%b exp 0100/00100000/1/0",
               ack, wen, wrdata, busy);
    end
    req = 4'b0;
    tick();
    checks++;
    if (ack !== 4'b0 || wen !== 8'd0 || wrdata !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_after got ack=%b wen=%b wd=%b busy=%b exp 0/0/1(hold)/0",
               ack, wen, wrdata, busy);
    end
  endtask

  task automatic test_round_robin();
    int exp_g [5] = '{0, 1, 2, 3, 0};
    int a_of [4] = '{2, 4, 1, 6};
    do_reset();
    addr = {3'd6, 3'd1, 3'd4, 3'd2}; data = 4'b1010;
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      tick();
      tick();
      checks++;
      if (ack !== 4'b0 || wen !== 8'd0) begin
        failures++; $display("FAIL rr_gap t=%0d got ack=%b wen=%b exp 0/0", t, ack, wen);
      end
      tick();
      checks++;
      if (ack !== (4'b1 << exp_g[t]) || wen !== (8'b1 << a_of[exp_g[t]]) ||
          wrdata !== data[exp_g[t]]) begin
        failures++;
        $display("FAIL rr_ack t=%0d got ack=%b wen=%b wd=%b exp req %0d addr %0d wd=%b",
                 t, ack, wen, wrdata, exp_g[t], a_of[exp_g[t]], data[exp_g[t]]);
      end
    end
    req = 4'b0;
    tick();
  endtask

  task automatic test_addr_err();
    do_reset();
    e_addr = {3'd0, 3'd0, 3'd7, 3'd0}; e_data = 4'b0010;
    e_req = 4'b0010;
    tick();
    checks++;
    if (e_busy !== 1'b1) begin
      failures++; $display("FAIL aerr_busy got %b exp 1", e_busy);
    end
    tick(); tick();
    checks++;
    if (e_ack !== 4'b0010 || e_wen !== 6'd0 || e_err !== 1'b1) begin
      failures++;
      $display("FAIL aerr_pulse got ack=%b wen=%b err=%b exp 0010/000000/1", e_ack, e_wen, e_err);
    end
    e_req = 4'b0;
    tick();
    checks++;
    if (e_err !== 1'b0 || e_ack !== 4'b0) begin
      failures++; $display("FAIL aerr_clear got err=%b ack=%b exp 0/0000", e_err, e_ack);
    end
    // pointer must now be at 2: requester 2 (addr DEPTH-1) beats requester 0
    e_addr = {3'd0, 3'd5, 3'd7, 3'd6}; e_data = 4'b0100;
    e_req = 4'b0101;
    tick(); tick(); tick();
    checks++;
    if (e_ack !== 4'b0100 || e_wen !== 6'b100000 || e_err !== 1'b0 || e_wrdata !== 1'b1) begin
      failures++;
      $display("FAIL aerr_rrptr got ack=%b wen=%b err=%b wd=%b exp 0100/100000/0/1",
               e_ack, e_wen, e_err, e_wrdata);
    end
    e_req = 4'b0001;
    tick(); tick(); tick();
    checks++;
    if (e_ack !== 4'b0001 || e_wen !== 6'd0 || e_err !== 1'b1) begin
      failures++;
      $display("FAIL aerr_eq_depth got ack=%b wen=%b err=%b exp 0001/000000/1", e_ack, e_wen, e_err);
    end
    e_req = 4'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    addr = {3'd6, 3'd5, 3'd4, 3'd2}; data = 4'b0100;
    req = 4'b0100;
    tick(); tick(); tick();
    req = 4'b0;
    tick();
    // pointer now at 3; start a grant to 3 then reset during GRANT
    req = 4'b1111;
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (ack !== 4'b0 || wen !== 8'd0 || busy !== 1'b0) begin
      failures++; $display("FAIL rmid_reset got ack=%b wen=%b busy=%b exp 0/0/0", ack, wen, busy);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (ack !== 4'b0 || wen !== 8'd0) begin
        failures++; $display("FAIL rmid_quiet c=%0d got ack=%b wen=%b exp 0/0", c, ack, wen);
      end
    end
    tick();
    checks++;
    if (ack !== 4'b0001 || wen !== 8'b0000_0100) begin
      failures++; $display("FAIL rmid_restart got ack=%b wen=%b exp 0001/00000100", ack, wen);
    end
    req = 4'b0;
    tick();
  endtask

  task automatic test_lock();
`ifdef ARB_LOCK_EN
    int exp_g [4] = '{0, 0, 0, 3};
`else
    int exp_g [4] = '{0, 3, 0, 3};
`endif
    do_reset();
    addr = {3'd6, 3'd1, 3'd4, 3'd2}; data = 4'b1001;
    lock = 4'b0001;
    req = 4'b1001;
    for (int t = 0; t < 4; t++) begin
      tick(); tick(); tick();
      checks++;
      if (ack !== (4'b1 << exp_g[t])) begin
        failures++; $display("FAIL lock_order t=%0d got ack=%b exp req %0d", t, ack, exp_g[t]);
      end
      if (t == 1) lock = 4'b0;
    end
    req = 4'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    req = '0; lock = '0; addr = '0; data = '0;
    e_req = '0; e_addr = '0; e_data = '0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_addr_err();
    test_reset_mid();
    test_lock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
